// File: rtl/jam_pkg.sv
// Shared constants, widths and FSM state encoding for the jam cost server.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Imported by the interface, the cost memory and the top module so that all
// widths stay consistent across the slice.
package jam_pkg;

    // Problem geometry: JAM_N workers by JAM_N jobs, flattened row-major.
    localparam int JAM_N     = 8;
    localparam int JAM_DEPTH = JAM_N * JAM_N;
    localparam int IDX_W     = 6;          // log2(JAM_DEPTH)
    localparam int SEL_W     = 3;          // log2(JAM_N), width of W and J

    // Data widths.
    localparam int COST_W = 7;             // single cost entry
    localparam int SUM_W  = 10;            // minimum assignment cost
    localparam int CNT_W  = 4;             // number of optimal matchings

    // Result wait watchdog.
    localparam int                 WAIT_W        = 18;
    localparam logic [WAIT_W-1:0]  TIMEOUT_LIMIT = 18'd262143;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } jam_state_t;

endpackage : jam_pkg

// File: rtl/jam_cost_server_if.sv
// Bundle of the load, solver-read, result and status signals of the server.
// Latency: n/a (wiring only).
// Backpressure: ld_ready is the only flow-control signal; the solver side has none.
//
// slave  : the cost server (consumes loads, serves reads, reports status)
// master : the environment (loads the matrix, acts as solver, observes status)
interface jam_cost_server_if;
    import jam_pkg::*;

    // Matrix load channel.
    logic                ld_valid;
    logic [COST_W-1:0]   ld_data;
    logic                ld_ready;
    logic [SUM_W-1:0]    exp_min_cost;
    logic [CNT_W-1:0]    exp_match;

    // Solver read port.
    logic [SEL_W-1:0]    W;
    logic [SEL_W-1:0]    J;
    logic [COST_W-1:0]   Cost;

    // Solver result.
    logic [SUM_W-1:0]    MinCost;
    logic [CNT_W-1:0]    MatchCount;
    logic                Valid;

    // Status and captured results.
    logic                done;
    logic                pass;
    logic                seq_err;
    logic                timeout;
    logic [SUM_W-1:0]    cap_min_cost;
    logic [CNT_W-1:0]    cap_match;

    modport slave (
        input  ld_valid, ld_data, exp_min_cost, exp_match,
        input  W, J, MinCost, MatchCount, Valid,
        output ld_ready, Cost,
        output done, pass, seq_err, timeout, cap_min_cost, cap_match
    );

    modport master (
        output ld_valid, ld_data, exp_min_cost, exp_match,
        output W, J, MinCost, MatchCount, Valid,
        input  ld_ready, Cost,
        input  done, pass, seq_err, timeout, cap_min_cost, cap_match
    );

endinterface : jam_cost_server_if

// File: rtl/jam_cost_mem.sv
// 64x7 cost register file: one synchronous write port, one asynchronous read port.
// Latency: write visible on the next cycle; read is combinational.
// Backpressure: none; every write strobe is accepted.
//
// Ports:
//   clk_i              write clock
//   we_i/waddr_i/wdata_i  write port
//   raddr_i/rdata_o    asynchronous read port
// Contents are deliberately not reset; the owner reloads all entries after reset.
module jam_cost_mem
    import jam_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [COST_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [COST_W-1:0] rdata_o
);

    logic [COST_W-1:0] mem_q [JAM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : jam_cost_mem

// File: rtl/jam_cost_server.sv
// Serves a loaded 8x8 cost matrix to a solver, polices its read order and checks its result.
// Latency: Cost is combinational from W/J; status flags update one cycle after the cause.
// Backpressure: ld_ready is high only while loading; solver reads and results are never stalled.
//
// Ports:
//   CLK, RST (async, active-low)
//   bus (slave modport of jam_cost_server_if):
//     load    : ld_valid, ld_data, ld_ready, exp_min_cost, exp_match
//     read    : W, J -> Cost
//     result  : MinCost, MatchCount, Valid
//     status  : done, pass, seq_err, timeout, cap_min_cost, cap_match
// WAIT_LIMIT defaults to the full watchdog value; it is a parameter only so a
// shorter watchdog can be instantiated.
module jam_cost_server
    import jam_pkg::*;
#(
    parameter logic [WAIT_W-1:0] WAIT_LIMIT = TIMEOUT_LIMIT
) (
    input  logic              CLK,
    input  logic              RST,
    jam_cost_server_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    jam_state_t         state_q,      state_d;
    logic [IDX_W-1:0]   ld_idx_q,     ld_idx_d;
    logic [IDX_W-1:0]   rd_idx_q,     rd_idx_d;
    logic [WAIT_W-1:0]  wait_cnt_q,   wait_cnt_d;
    logic               done_q,       done_d;
    logic               pass_q,       pass_d;
    logic               seq_err_q,    seq_err_d;
    logic               timeout_q,    timeout_d;
    logic [SUM_W-1:0]   cap_min_q,    cap_min_d;
    logic [CNT_W-1:0]   cap_match_q,  cap_match_d;
    logic [SUM_W-1:0]   exp_min_q,    exp_min_d;
    logic [CNT_W-1:0]   exp_match_q,  exp_match_d;

    logic               mem_we;
    logic [COST_W-1:0]  mem_rdata;
    logic [IDX_W-1:0]   rd_addr;
    logic [IDX_W-1:0]   rd_prev;

    // Flattened solver address, row-major (worker-major).
    assign rd_addr = {bus.W, bus.J};
    // Address the solver may legally keep holding after a successful read.
    assign rd_prev = rd_idx_q - IDX_W'(1);

    // ------------------------------------------------------------------
    // Cost memory
    // ------------------------------------------------------------------
    jam_cost_mem u_mem (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .waddr_i (ld_idx_q),
        .wdata_i (bus.ld_data),
        .raddr_i (rd_addr),
        .rdata_o (mem_rdata)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_LOAD;
            ld_idx_q    <= '0;
            rd_idx_q    <= '0;
            wait_cnt_q  <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            seq_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
            cap_min_q   <= '0;
            cap_match_q <= '0;
            exp_min_q   <= '0;
            exp_match_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_idx_q    <= ld_idx_d;
            rd_idx_q    <= rd_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            seq_err_q   <= seq_err_d;
            timeout_q   <= timeout_d;
            cap_min_q   <= cap_min_d;
            cap_match_q <= cap_match_d;
            exp_min_q   <= exp_min_d;
            exp_match_q <= exp_match_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ld_idx_d    = ld_idx_q;
        rd_idx_d    = rd_idx_q;
        wait_cnt_d  = wait_cnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        seq_err_d   = seq_err_q;
        timeout_d   = timeout_q;
        cap_min_d   = cap_min_q;
        cap_match_d = cap_match_q;
        exp_min_d   = exp_min_q;
        exp_match_d = exp_match_q;
        mem_we      = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (bus.Valid) begin
                    // A result before the matrix is even loaded is a protocol
                    // violation; abort with the capture registers untouched.
                    seq_err_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (bus.ld_valid) begin
                    mem_we   = 1'b1;
                    ld_idx_d = ld_idx_q + IDX_W'(1);
                    if (ld_idx_q == IDX_W'(JAM_DEPTH - 1)) begin
                        exp_min_d   = bus.exp_min_cost;
                        exp_match_d = bus.exp_match;
                        ld_idx_d    = '0;
                        state_d     = ST_SERVE;
                    end
                end
            end

            ST_SERVE: begin
                if (bus.Valid) begin
                    seq_err_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (rd_addr == rd_idx_q) begin
                    // Expected next address: advance. Wrapping back to 0 after
                    // the last entry leaves rd_idx clean for the next run.
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                    if (rd_idx_q == IDX_W'(JAM_DEPTH - 1)) begin
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end
                end else if ((rd_idx_q != '0) && (rd_addr == rd_prev)) begin
                    // Solver still presenting the address it just read.
                end else begin
                    // Out-of-order read: flag it but keep tracking from the
                    // same point so a recovering solver can still finish.
                    seq_err_d = 1'b1;
                end
            end

            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                // Valid is checked first so a result on the last allowed
                // cycle is still accepted.
                if (bus.Valid) begin
                    cap_min_d   = bus.MinCost;
                    cap_match_d = bus.MatchCount;
                    pass_d      = (bus.MinCost == exp_min_q)
                               && (bus.MatchCount == exp_match_q)
                               && !seq_err_q
                               && !timeout_q;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                // Absorbing until reset; every input is ignored.
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ld_ready     = (state_q == ST_LOAD);
    // Memory contents are stale or partial while loading, so reads return 0.
    assign bus.Cost         = (state_q == ST_LOAD) ? '0 : mem_rdata;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.seq_err      = seq_err_q;
    assign bus.timeout      = timeout_q;
    assign bus.cap_min_cost = cap_min_q;
    assign bus.cap_match    = cap_match_q;

endmodule : jam_cost_server
